// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared types and helpers for the RTC bus driver.
//   state_t    : transfer FSM states (IDLE, TURN, DRIVE, SAMPLE, DONE)
//   DIR_WR/RD  : per-source direction encoding (1 = drive, 0 = sample)
//   max3       : sizes the shared phase counter
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TURN   = 3'd1,
        DRIVE  = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic DIR_WR = 1'b1;
    localparam logic DIR_RD = 1'b0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rtc_bus_arb.sv
// rtc_bus_arb: picks one requesting source when enabled.
//   Default build : fixed priority, lowest index wins.
//   RTC_BUS_RR_ARB_EN defined : round-robin, search starts at last_idx+1.
// Ports:
//   req      in  N_SRC  request vector
//   last_idx in  IDX_W  index of the most recently granted source
//   en       in  1      arbitration enable (high only in IDLE)
//   gnt      out N_SRC  one-hot grant, zero when disabled or no request
//   gnt_idx  out IDX_W  index of the granted source (0 when none)
module rtc_bus_arb #(
    parameter int N_SRC = 3,
    parameter int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] last_idx,
    input  logic             en,
    output logic [N_SRC-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    // Only consumed by the round-robin build.
    logic unused_last;
    assign unused_last = ^last_idx;

    always_comb begin
        int  j;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
`ifdef RTC_BUS_RR_ARB_EN
        // Walk the ring starting just past the last winner.
        for (int k = 1; k <= N_SRC; k++) begin
            j = int'(last_idx) + k;
            if (j >= N_SRC) j = j - N_SRC;
            if (en && !found && req[j]) begin
                found      = 1'b1;
                gnt[j]     = 1'b1;
                gnt_idx    = IDX_W'(j);
            end
        end
`else
        for (int i = 0; i < N_SRC; i++) begin
            j = i;
            if (en && !found && req[j]) begin
                found      = 1'b1;
                gnt[j]     = 1'b1;
                gnt_idx    = IDX_W'(j);
            end
        end
`endif
    end

endmodule

// File: rtl/rtc_bus_mux_param.sv
// rtc_bus_mux_param: arbitrated driver for the bidirectional RTC bus.
// A granted source gets a high-Z turnaround, then either HOLD_CYC cycles
// of its latched word on RTC, or SAMPLE_DLY released cycles ending in a
// capture of RTC into rd_data. Every output is registered.
// Build option: RTC_BUS_RR_ARB_EN selects round-robin arbitration
// (default build: fixed priority, lowest index wins).
// Ports:
//   clk, reset_n   clock / async active-low reset
//   src_req        per-source level request
//   src_dir        per-source direction (1 = write/drive, 0 = read/sample)
//   src_data       per-source words, source i at [i*DATA_W +: DATA_W]
//   src_gnt        one-hot grant held for the whole transaction
//   done           one-cycle pulse in the DONE state
//   rd_data        last word captured from RTC
//   rd_valid       pulses with done for reads
//   busy           high from grant through DONE
//   bus_oe         high only while RTC is driven (DRIVE state)
//   RTC            tristate bus
module rtc_bus_mux_param
    import rtc_bus_pkg::*;
#(
    parameter int DATA_W     = 9,
    parameter int N_SRC      = 3,
    parameter int TURN_CYC   = 1,
    parameter int HOLD_CYC   = 2,
    parameter int SAMPLE_DLY = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_SRC-1:0]          src_req,
    input  logic [N_SRC-1:0]          src_dir,
    input  logic [N_SRC*DATA_W-1:0]   src_data,
    output logic [N_SRC-1:0]          src_gnt,
    output logic                      done,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_valid,
    output logic                      busy,
    output logic                      bus_oe,
    inout  wire  [DATA_W-1:0]         RTC
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CNT_W = $clog2(max3(TURN_CYC, HOLD_CYC, SAMPLE_DLY) + 1);

    // Counter runs 0..N-1 in each timed phase.
    localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_DLY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [N_SRC-1:0]    gnt_q,      gnt_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic                rd_valid_q, rd_valid_d;
    logic                bus_oe_q,   bus_oe_d;
    logic [DATA_W-1:0]   word_q,     word_d;
    logic                dir_q,      dir_d;
    logic [DATA_W-1:0]   rd_data_q,  rd_data_d;
    logic [IDX_W-1:0]    last_q,     last_d;

    logic [N_SRC-1:0]    arb_gnt;
    logic [IDX_W-1:0]    arb_idx;

    rtc_bus_arb #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_arb (
        .req      (src_req),
        .last_idx (last_q),
        .en       (state_q == IDLE),
        .gnt      (arb_gnt),
        .gnt_idx  (arb_idx)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd_valid_d = 1'b0;
        bus_oe_d   = 1'b0;
        word_d     = word_q;
        dir_d      = dir_q;
        rd_data_d  = rd_data_q;
        last_d     = last_q;
        case (state_q)
            IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (|arb_gnt) begin
                    state_d = TURN;
                    gnt_d   = arb_gnt;
                    busy_d  = 1'b1;
                    word_d  = src_data[arb_idx*DATA_W +: DATA_W];
                    dir_d   = src_dir[arb_idx];
                    last_d  = arb_idx;
                    cnt_d   = '0;
                end
            end
            TURN: begin
                if (cnt_q == TURN_LAST) begin
                    cnt_d = '0;
                    if (dir_q == DIR_WR) begin
                        state_d  = DRIVE;
                        bus_oe_d = 1'b1;   // registered: drives from first DRIVE cycle
                    end else begin
                        state_d  = SAMPLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DRIVE: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d    = cnt_q + CNT_ONE;
                    bus_oe_d = 1'b1;
                end
            end
            SAMPLE: begin
                if (cnt_q == SAMPLE_LAST) begin
                    cnt_d      = '0;
                    state_d    = DONE;
                    done_d     = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_data_d  = RTC;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            bus_oe_q   <= 1'b0;
            word_q     <= '0;
            dir_q      <= DIR_RD;
            rd_data_q  <= '0;
            // Treat the last winner as N_SRC-1 so source 0 leads after reset.
            last_q     <= IDX_W'(N_SRC - 1);
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            bus_oe_q   <= bus_oe_d;
            word_q     <= word_d;
            dir_q      <= dir_d;
            rd_data_q  <= rd_data_d;
            last_q     <= last_d;
        end
    end

    assign RTC      = bus_oe_q ? word_q : {DATA_W{1'bz}};
    assign src_gnt  = gnt_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_valid = rd_valid_q;
    assign bus_oe   = bus_oe_q;
    assign rd_data  = rd_data_q;

endmodule
